seg_display_ctrl: RTL and testbench

Parametrised multiplexed seven-segment display controller for the board top level. It latches a binary value on a load pulse and converts it to decimal (a sequential double-dabble, one bit per clock) or hex digits. It then time-multiplexes DIGITS digits, with per-digit decimal point, per-digit blink, leading-zero blanking and overflow indication. It replaces the fixed 4-digit, combinational-divide display driver.

---
 rtl/seg_pkg.sv | 22 ++
 rtl/seg7_decode.sv | 11 +
 rtl/seg_display_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_seg_display_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment controller: glyphs (active-low, g..a)
// and the conversion FSM state encoding.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Index = digit value 0..F; bit 6 is segment g, bit 0 is segment a.
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit digit to active-low seven-segment glyph (0-9, A b C d E F).
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = HEX_GLYPH[digit];

endmodule

// File: rtl/seg_display_ctrl.sv
// Multiplexed seven-segment controller: latches a value on load, converts it to
// BCD (one double-dabble step per clock) or hex, and scans DIGITS digits.
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DIGITS    = 4,
    parameter int DIV       = 100_000,
    parameter int BLINK_DIV = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  num,
    input  logic              load,
    input  logic              hex_mode,
    input  logic              lz_blank,
    input  logic [DIGITS-1:0] dp_mask,
    input  logic [DIGITS-1:0] blink_mask,
    output logic              busy,
    output logic              overflow,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [DIGITS-1:0] an
);

    localparam int BW   = 4 * DIGITS;
    localparam int EXTW = WIDTH + BW;
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int KW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int NW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t            state, state_next;
    logic [WIDTH-1:0]  num_q;
    logic              mode_q;
    logic [NW-1:0]     bit_cnt;
    logic [BW-1:0]     bcd, bcd_adj;
    logic              bcd_ovf;
    logic [BW-1:0]     digit_q;
    logic              ovf_q;
    logic [EXTW-1:0]   num_ext;

    logic [CW-1:0]     scan_cnt;
    logic [KW-1:0]     blink_cnt;
    logic [IW-1:0]     idx;
    logic              phase;
    logic              tick;

    logic [3:0]        cur_digit;
    logic [6:0]        dec_seg;
    logic [6:0]        seg_next;
    logic              dp_next;
    logic              blink_on;
    logic              upper_zero;
    logic              lz_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = hex_mode ? COMMIT : SHIFT;
            SHIFT:   if (bit_cnt == NW'(WIDTH - 1)) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy     = (state != IDLE);
    assign overflow = ovf_q;
    assign num_ext  = EXTW'(num_q);

    // Double-dabble adjust: every nibble >= 5 gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q   <= '0;
            mode_q  <= 1'b0;
            bit_cnt <= '0;
            bcd     <= '0;
            bcd_ovf <= 1'b0;
            digit_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (load) begin
                    num_q   <= num;
                    mode_q  <= hex_mode;
                    bit_cnt <= '0;
                    bcd     <= '0;
                    bcd_ovf <= 1'b0;
                end
                SHIFT: begin
                    bcd     <= {bcd_adj[BW-2:0], num_q[WIDTH-1]};
                    bcd_ovf <= bcd_ovf | bcd_adj[BW-1];
                    num_q   <= num_q << 1;
                    bit_cnt <= bit_cnt + 1'b1;
                end
                COMMIT: begin
                    // Digits and overflow update on the same edge so the scan never sees a mix.
                    if (mode_q) begin
                        digit_q <= num_ext[BW-1:0];
                        ovf_q   <= |num_ext[EXTW-1:BW];
                    end else begin
                        digit_q <= bcd;
                        ovf_q   <= bcd_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tick = (scan_cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            blink_cnt <= '0;
            idx       <= '0;
            phase     <= 1'b0;
        end else begin
            scan_cnt <= tick ? '0 : scan_cnt + 1'b1;
            if (tick) begin
                idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
                if (blink_cnt == KW'(BLINK_DIV - 1)) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    assign cur_digit = digit_q[{idx, 2'b00} +: 4];

    seg7_decode u_decode (
        .digit (cur_digit),
        .seg   (dec_seg)
    );

    // lz_hit: the current digit and every digit above it are zero.
    always_comb begin
        upper_zero = 1'b1;
        lz_hit     = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero & (digit_q[4*i +: 4] == 4'd0);
            if (IW'(i) == idx) lz_hit = upper_zero;
        end
    end

    assign blink_on = blink_mask[idx] & phase;

    always_comb begin
        seg_next = dec_seg;
        if (ovf_q)                                       seg_next = SEG_DASH;
        else if (blink_on)                               seg_next = SEG_BLANK;
        else if (lz_blank && (idx != '0) && lz_hit)      seg_next = SEG_BLANK;
        dp_next = blink_on ? 1'b1 : ~dp_mask[idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_BLANK;
            dp  <= 1'b1;
            an  <= '1;
        end else begin
            seg <= seg_next;
            dp  <= dp_next;
            an  <= ~(DIGITS'(1) << idx);
        end
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl: arithmetic reference model checked every cycle,
// directed scenarios with hand-computed glyphs, then randomized loads and masks.
module tb_seg_display_ctrl;

    localparam int WIDTH     = 16;
    localparam int DIGITS    = 4;
    localparam int DIV       = 4;
    localparam int BLINK_DIV = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [WIDTH-1:0]  num = '0;
    logic              load = 1'b0;
    logic              hex_mode = 1'b0;
    logic              lz_blank = 1'b0;
    logic [DIGITS-1:0] dp_mask = '0;
    logic [DIGITS-1:0] blink_mask = '0;
    logic              busy;
    logic              overflow;
    logic [6:0]        seg;
    logic              dp;
    logic [DIGITS-1:0] an;

    int n_vec = 0;
    int n_err = 0;

    seg_display_ctrl #(
        .WIDTH(WIDTH), .DIGITS(DIGITS), .DIV(DIV), .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .num(num), .load(load), .hex_mode(hex_mode),
        .lz_blank(lz_blank), .dp_mask(dp_mask), .blink_mask(blink_mask),
        .busy(busy), .overflow(overflow), .seg(seg), .dp(dp), .an(an)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input int d);
        case (d)
            0:  return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
            3:  return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
            6:  return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
            9:  return 7'b0010000; 10: return 7'b0001000; 11: return 7'b0000011;
            12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic int pow10(input int i);
        int r = 1;
        for (int k = 0; k < i; k++) r = r * 10;
        return r;
    endfunction

    function automatic int digit_of(input int val, input bit hx, input int i);
        return hx ? ((val >> (4 * i)) & 15) : ((val / pow10(i)) % 10);
    endfunction

    function automatic bit model_ovf(input int val, input bit hx);
        return hx ? ((val >> (4 * DIGITS)) != 0) : (val >= pow10(DIGITS));
    endfunction

    function automatic bit upper_zero(input int val, input bit hx, input int i);
        return hx ? ((val >> (4 * i)) == 0) : ((val / pow10(i)) == 0);
    endfunction

    // Reference model: scan position from the edge count since reset, display
    // contents as the integer value last committed.
    int         m_edges, m_busy_cnt, m_pend_val, m_disp_val, m_idx, m_phase;
    bit         m_pend_hex, m_disp_hex, m_blk;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic [3:0] exp_an;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_edges = 0; m_busy_cnt = 0; m_disp_val = 0; m_disp_hex = 0;
            exp_seg = 7'h7F; exp_dp = 1'b1; exp_an = 4'hF;
        end else begin
            m_idx   = (m_edges / DIV) % DIGITS;
            m_phase = ((m_edges / DIV) / BLINK_DIV) % 2;
            m_blk   = blink_mask[m_idx] && (m_phase == 1);
            exp_an  = 4'b1111 ^ (4'b0001 << m_idx);
            if (model_ovf(m_disp_val, m_disp_hex))                          exp_seg = 7'b0111111;
            else if (m_blk)                                                 exp_seg = 7'b1111111;
            else if (lz_blank && m_idx > 0 && upper_zero(m_disp_val, m_disp_hex, m_idx)) exp_seg = 7'b1111111;
            else exp_seg = glyph(digit_of(m_disp_val, m_disp_hex, m_idx));
            exp_dp = m_blk ? 1'b1 : ~dp_mask[m_idx];
            m_edges++;
            if (m_busy_cnt > 0) begin
                m_busy_cnt--;
                if (m_busy_cnt == 0) begin
                    m_disp_val = m_pend_val;
                    m_disp_hex = m_pend_hex;
                end
            end else if (load) begin
                m_pend_val = int'(num);
                m_pend_hex = hex_mode;
                m_busy_cnt = hex_mode ? 1 : WIDTH + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("seg", 32'(seg), 32'(exp_seg));
        check("dp", 32'(dp), 32'(exp_dp));
        check("an", 32'(an), 32'(exp_an));
        check("busy", 32'(busy), 32'(m_busy_cnt > 0));
        check("overflow", 32'(overflow), 32'(model_ovf(m_disp_val, m_disp_hex)));
    end

    logic [6:0] cap_seg [DIGITS];

    task automatic pulse_load(input int val, input bit hx);
        @(negedge clk);
        num = WIDTH'(val);
        hex_mode = hx;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic do_load(input int val, input bit hx, output int busy_len);
        pulse_load(val, hx);
        busy_len = 0;
        while (busy && busy_len < 100) begin
            busy_len++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic scan_capture();
        for (int i = 0; i < DIGITS; i++) cap_seg[i] = 7'bx;
        for (int c = 0; c < 2 * DIV * DIGITS + 2; c++) begin
            @(negedge clk);
            for (int i = 0; i < DIGITS; i++)
                if (an == (4'b1111 ^ (4'b0001 << i))) cap_seg[i] = seg;
        end
    endtask

    task automatic check_digits(input string name, input logic [6:0] d3, input logic [6:0] d2,
                                input logic [6:0] d1, input logic [6:0] d0);
        scan_capture();
        check({name, "_d0"}, 32'(cap_seg[0]), 32'(d0));
        check({name, "_d1"}, 32'(cap_seg[1]), 32'(d1));
        check({name, "_d2"}, 32'(cap_seg[2]), 32'(d2));
        check({name, "_d3"}, 32'(cap_seg[3]), 32'(d3));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int blen, dp_bad, blank_seen, lit_seen;

        repeat (3) @(negedge clk);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 32'd1);
        check("rst_an", 32'(an), 32'hF);
        check("rst_busy", 32'(busy), 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("first_an", 32'(an), 32'b1110);
        check("first_seg", 32'(seg), 32'b1000000);

        do_load(1234, 1'b0, blen);
        check("dec_busy_len", 32'(blen), 32'd17);
        check("dec_ovf", 32'(overflow), 32'd0);
        check_digits("dec1234", 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001);

        do_load(12345, 1'b0, blen);
        check("ovf_set", 32'(overflow), 32'd1);
        check_digits("ovf", 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111);
        do_load(9999, 1'b0, blen);
        check("ovf_clear", 32'(overflow), 32'd0);
        check_digits("dec9999", 7'b0010000, 7'b0010000, 7'b0010000, 7'b0010000);

        do_load(16'hBEEF, 1'b1, blen);
        check("hex_busy_len", 32'(blen), 32'd1);
        check_digits("hexbeef", 7'b0000011, 7'b0000110, 7'b0000110, 7'b0001110);

        lz_blank = 1'b1;
        do_load(7, 1'b0, blen);
        check_digits("lz7", 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000);
        do_load(0, 1'b0, blen);
        check_digits("lz0", 7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000);
        lz_blank = 1'b0;

        // With DIV=4, BLINK_DIV=2 and four digits the blink phase repeats every
        // scan: digits 0/1 always land on phase 0, digits 2/3 on phase 1.
        do_load(1234, 1'b0, blen);
        blink_mask = 4'b0010;
        dp_mask = 4'b0100;
        dp_bad = 0;
        @(negedge clk);
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if ((dp == 1'b0) != (an == 4'b1011)) dp_bad++;
        end
        check("dp_only_digit2", 32'(dp_bad), 32'd0);
        check_digits("blink1", 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001);
        blink_mask = 4'b0100;
        blank_seen = 0;
        lit_seen = 0;
        @(negedge clk);
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (an == 4'b1011 && seg == 7'b1111111 && dp == 1'b1) blank_seen++;
            if (an == 4'b1011 && seg != 7'b1111111) lit_seen++;
        end
        check("blink2_blank_seen", 32'(blank_seen > 0), 32'd1);
        check("blink2_lit_seen", 32'(lit_seen), 32'd0);
        blink_mask = '0;
        dp_mask = '0;

        pulse_load(1234, 1'b0);
        repeat (2) @(negedge clk);
        pulse_load(5555, 1'b0);
        wait_idle();
        check_digits("ignored_load", 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001);

        pulse_load(4321, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("abort_busy", 32'(busy), 32'd0);
        check("abort_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("abort_an", 32'(an), 32'b1110);
        check("abort_seg", 32'(seg), 32'b1000000);

        for (int it = 0; it < 300; it++) begin
            int v;
            bit hx;
            if ($urandom_range(0, 3) == 0) lz_blank = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) dp_mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) blink_mask = 4'($urandom_range(0, 15));
            hx = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(0, 99);
                1:       v = $urandom_range(0, 9999);
                2:       v = $urandom_range(10000, 65535);
                default: v = $urandom_range(0, 65535);
            endcase
            if ($urandom_range(0, 2) != 0) pulse_load(v, hx);
            if (it % 60 == 59) begin
                @(negedge clk);
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
            repeat ($urandom_range(0, 25)) @(negedge clk);
        end

        wait_idle();
        repeat (20) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
